// File: rtl/clock_divider_multi.sv
// -----------------------------------------------------------------------------
// clock_divider_multi
//
// NUM_CH independent programmable clock dividers driven by one system clock.
// Each channel counts 0..div_active. When the count reaches div_active, the
// channel returns to 0, toggles its square-wave output and raises a one-cycle
// tick. The toggle interval is div+1 cycles, so the output period is
// 2*(div+1) cycles.
//
// A divisor write goes to a per-channel shadow register and marks the channel
// pending. The shadow is copied to the active divisor only at a safe point:
//   - the channel's next terminal count (the counter is back at 0, so the
//     output never glitches),
//   - any edge where the channel is disabled, or
//   - a global sync_clr.
//
// Optional build macro: DIV_DUTY_EN
//   Adds cfg_high, a programmable high time per channel that follows the same
//   shadow/pending rules as the divisor. clk_out then becomes
//   (next count < high_active), and the period is div+1 cycles.
//
// Ports
//   clk       in   system clock; all logic on the rising edge
//   rst       in   synchronous active-low reset
//   en        in   [NUM_CH]  per-channel run enable
//   sync_clr  in   one-cycle global phase-align clear
//   cfg_wr    in   divisor write strobe
//   cfg_ch    in   [CH_W]    channel targeted by cfg_wr; out-of-range is ignored
//   cfg_div   in   [CNT_W]   new divisor
//   cfg_high  in   [CNT_W]   new high count (DIV_DUTY_EN builds only)
//   clk_out   out  [NUM_CH]  divided clock per channel (registered)
//   tick      out  [NUM_CH]  terminal-count strobe (registered)
//   pending   out  [NUM_CH]  a written divisor is waiting to be applied
// -----------------------------------------------------------------------------
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 49999999,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef DIV_DUTY_EN
  input  logic [CNT_W-1:0]  cfg_high,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = '0;

  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [CNT_W-1:0]  cnt_d     [NUM_CH];
  logic [CNT_W-1:0]  div_act_q [NUM_CH];
  logic [CNT_W-1:0]  div_act_d [NUM_CH];
  logic [CNT_W-1:0]  div_sh_q  [NUM_CH];
  logic [CNT_W-1:0]  div_sh_d  [NUM_CH];
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] pend_q, pend_d;

  // Per-channel helper vectors.
  logic [NUM_CH-1:0] wr_sel;   // this channel is the target of a write
  logic [NUM_CH-1:0] term;     // counter at or past the active divisor
  logic [NUM_CH-1:0] apply;    // copy the shadow into the active register now

`ifdef DIV_DUTY_EN
  localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'((DEFAULT_DIV + 1) / 2);
  logic [CNT_W-1:0] high_act_q [NUM_CH];
  logic [CNT_W-1:0] high_act_d [NUM_CH];
  logic [CNT_W-1:0] high_sh_q  [NUM_CH];
  logic [CNT_W-1:0] high_sh_d  [NUM_CH];
`endif

  always_comb begin
    wr_sel    = '0;
    term      = '0;
    apply     = '0;
    clk_out_d = clk_out_q;
    tick_d    = '0;
    pend_d    = pend_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      div_act_d[i] = div_act_q[i];
      div_sh_d[i]  = div_sh_q[i];
`ifdef DIV_DUTY_EN
      high_act_d[i] = high_act_q[i];
      high_sh_d[i]  = high_sh_q[i];
`endif
      // An out-of-range cfg_ch matches no channel, so the write is dropped.
      wr_sel[i] = cfg_wr && (int'(cfg_ch) == i);
      // The >= compare means a divisor lowered below the current count
      // still terminates on the next edge instead of wrapping.
      term[i]   = (cnt_q[i] >= div_act_q[i]);

      if (sync_clr) begin
        cnt_d[i]     = ZERO;
        clk_out_d[i] = 1'b0;
        apply[i]     = pend_q[i];
      end else if (en[i]) begin
        if (term[i]) begin
          cnt_d[i]     = ZERO;
          clk_out_d[i] = ~clk_out_q[i];
          tick_d[i]    = 1'b1;
          apply[i]     = pend_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end else begin
        // A stopped channel has no phase to protect, so apply right away.
        apply[i] = pend_q[i];
      end

      if (apply[i]) begin
        div_act_d[i] = div_sh_q[i];
`ifdef DIV_DUTY_EN
        high_act_d[i] = high_sh_q[i];
`endif
        pend_d[i] = 1'b0;
      end

`ifdef DIV_DUTY_EN
      // In duty mode the output is level-coded from the next count. A held
      // (disabled) channel keeps its last level.
      if (sync_clr || en[i]) begin
        clk_out_d[i] = (cnt_d[i] < high_act_d[i]);
      end
`endif

      // The write lands after any apply at this edge, so a write that
      // coincides with a terminal count or sync_clr stays pending.
      if (wr_sel[i]) begin
        div_sh_d[i] = cfg_div;
`ifdef DIV_DUTY_EN
        high_sh_d[i] = cfg_high;
`endif
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_out_q <= '0;
      tick_q    <= '0;
      pend_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= ZERO;
        div_act_q[i] <= DEF_DIV;
        div_sh_q[i]  <= DEF_DIV;
`ifdef DIV_DUTY_EN
        high_act_q[i] <= DEF_HIGH;
        high_sh_q[i]  <= DEF_HIGH;
`endif
      end
    end else begin
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= cnt_d[i];
        div_act_q[i] <= div_act_d[i];
        div_sh_q[i]  <= div_sh_d[i];
`ifdef DIV_DUTY_EN
        high_act_q[i] <= high_act_d[i];
        high_sh_q[i]  <= high_sh_d[i];
`endif
      end
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// -----------------------------------------------------------------------------
// Directed bench for clock_divider_multi.
// Main instance: NUM_CH=4, CNT_W=8, DEFAULT_DIV=3.
// Second instance: NUM_CH=5 (CH_W=3), so that cfg_ch=7 is a legal encoding
// that addresses no channel.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// k counts rising edges since reset release.
// -----------------------------------------------------------------------------
module tb_clock_divider_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic       sync_clr;
  logic       cfg_wr;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] clk_out, tick, pending;

  logic [4:0] en5;
  logic       cfg_wr5;
  logic [2:0] cfg_ch5;
  logic [7:0] cfg_div5;
  logic [4:0] clk_out5, tick5, pending5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_divider_multi #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
`ifdef DIV_DUTY_EN
    .cfg_high(8'd2),
`endif
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  clock_divider_multi #(.NUM_CH(5), .CNT_W(8), .DEFAULT_DIV(3)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .sync_clr(1'b0),
    .cfg_wr(cfg_wr5), .cfg_ch(cfg_ch5), .cfg_div(cfg_div5),
`ifdef DIV_DUTY_EN
    .cfg_high(8'd2),
`endif
    .clk_out(clk_out5), .tick(tick5), .pending(pending5)
  );

  // Hand-derived expectations, one entry per sampled cycle.
  // Bit order: {ch3, ch2, ch1, ch0}.
  // Write ch1 div=1 mid-count (k13..24).
  logic [3:0] p2_t [12] = '{4'h0,4'h0,4'h0,4'hF,4'h0,4'h2,4'h0,4'hF,4'h0,4'h2,4'h0,4'hF};
  logic [3:0] p2_c [12] = '{4'hF,4'hF,4'hF,4'h0,4'h0,4'h2,4'h2,4'hD,4'hD,4'hF,4'hF,4'h0};
  logic [3:0] p2_p [12] = '{4'h0,4'h2,4'h2,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0};
  // Write ch2 div=1 on its terminal-count edge (k25..36).
  logic [3:0] p3_t [12] = '{4'h0,4'h2,4'h0,4'hF,4'h0,4'h2,4'h0,4'hF,4'h0,4'h6,4'h0,4'hF};
  logic [3:0] p3_c [12] = '{4'h0,4'h2,4'h2,4'hD,4'hD,4'hF,4'hF,4'h0,4'h0,4'h6,4'h6,4'h9};
  logic [3:0] p3_p [12] = '{4'h0,4'h0,4'h0,4'h4,4'h4,4'h4,4'h4,4'h0,4'h0,4'h0,4'h0,4'h0};
  // After sync_clr: ch3 div=1 applied, ch0 div=2 still pending (k53..62).
  logic [3:0] p5_t [10] = '{4'h0,4'hE,4'h0,4'hF,4'h0,4'hE,4'h1,4'hE,4'h0,4'hF};
  logic [3:0] p5_c [10] = '{4'h0,4'hE,4'hE,4'h1,4'h1,4'hF,4'hE,4'h0,4'h0,4'hF};
  logic [3:0] p5_p [10] = '{4'h1,4'h1,4'h1,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample_main(input int k, input logic [3:0] et, input logic [3:0] ec,
                             input logic [3:0] ep);
    @(negedge clk);
    check_eq($sformatf("tick k%0d", k),    {28'd0, tick},    {28'd0, et});
    check_eq($sformatf("clk_out k%0d", k), {28'd0, clk_out}, {28'd0, ec});
    check_eq($sformatf("pending k%0d", k), {28'd0, pending}, {28'd0, ep});
  endtask

  initial begin
    rst = 1'b0; en = 4'hF; sync_clr = 1'b0;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;
    en5 = 5'h1F; cfg_wr5 = 1'b0; cfg_ch5 = '0; cfg_div5 = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("reset clk_out", {28'd0, clk_out}, 32'd0);
    check_eq("reset tick",    {28'd0, tick},    32'd0);
    check_eq("reset pending", {28'd0, pending}, 32'd0);
    check_eq("reset pending5", {27'd0, pending5}, 32'd0);
    rst = 1'b1;

    // Free run with default div=3: toggle every 4 cycles, ticks on k=4,8,12.
    // dut5: cfg_ch=7 write ignored; ch4 div=1 written on edge 6 and applied on edge 8.
    for (int k = 1; k <= 12; k++) begin
      logic [4:0] e_t5, e_p5;
      sample_main(k, (k % 4 == 0) ? 4'hF : 4'h0, ((k / 4) % 2 == 1) ? 4'hF : 4'h0, 4'h0);
      e_t5 = (k % 4 == 0) ? 5'h1F : ((k == 10) ? 5'h10 : 5'h00);
      e_p5 = (k == 6 || k == 7) ? 5'h10 : 5'h00;
      check_eq($sformatf("tick5 k%0d", k),    {27'd0, tick5},    {27'd0, e_t5});
      check_eq($sformatf("pending5 k%0d", k), {27'd0, pending5}, {27'd0, e_p5});
      cfg_wr5 = 1'b0;
      if (k == 2) begin cfg_wr5 = 1'b1; cfg_ch5 = 3'd7; cfg_div5 = 8'd0; end
      if (k == 5) begin cfg_wr5 = 1'b1; cfg_ch5 = 3'd4; cfg_div5 = 8'd1; end
    end

    // Write ch1 div=1 mid-count (captured on edge 14).
    for (int k = 13; k <= 24; k++) begin
      sample_main(k, p2_t[k-13], p2_c[k-13], p2_p[k-13]);
      cfg_wr = (k == 13);
      cfg_ch = 2'd1; cfg_div = 8'd1;
    end
    cfg_wr = 1'b0;

    // Write ch2 div=1 on its terminal-count edge 28: the old divisor runs one more interval.
    for (int k = 25; k <= 36; k++) begin
      sample_main(k, p3_t[k-25], p3_c[k-25], p3_p[k-25]);
      cfg_wr = (k == 27);
      cfg_ch = 2'd2; cfg_div = 8'd1;
    end
    cfg_wr = 1'b0;

    // Hold ch0 for edges 38..47 at count 1; it resumes and terminates on edge 50.
    for (int k = 37; k <= 50; k++) begin
      @(negedge clk);
      check_eq($sformatf("tick0 k%0d", k),    {31'd0, tick[0]},    {31'd0, (k == 50)});
      check_eq($sformatf("clk_out0 k%0d", k), {31'd0, clk_out[0]}, {31'd0, (k < 50)});
      check_eq($sformatf("pending k%0d", k),  {28'd0, pending},    32'd0);
      if (k == 37) en = 4'hE;
      if (k == 47) en = 4'hF;
    end

    // Channels are now skewed. Queue ch3 div=1, then sync_clr together with a ch0 write.
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd1;
    @(negedge clk);
    check_eq("pending before clr", {28'd0, pending}, 32'h8);
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2; sync_clr = 1'b1;
    @(negedge clk);
    check_eq("clk_out after clr", {28'd0, clk_out}, 32'd0);
    check_eq("tick after clr",    {28'd0, tick},    32'd0);
    check_eq("pending after clr", {28'd0, pending}, 32'h1);
    cfg_wr = 1'b0; sync_clr = 1'b0;
    for (int k = 53; k <= 62; k++) begin
      sample_main(k, p5_t[k-53], p5_c[k-53], p5_p[k-53]);
    end

    // Queue a ch1 change, then pulse reset for one cycle mid-run.
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
    @(negedge clk);
    check_eq("pending before rst", {28'd0, pending}, 32'h2);
    cfg_wr = 1'b0; rst = 1'b0;
    @(negedge clk);
    check_eq("rst clk_out", {28'd0, clk_out}, 32'd0);
    check_eq("rst tick",    {28'd0, tick},    32'd0);
    check_eq("rst pending", {28'd0, pending}, 32'd0);
    rst = 1'b1;
    // All divisors are back to 3: toggle every 4 cycles again.
    for (int j = 1; j <= 8; j++) begin
      sample_main(64 + j, (j % 4 == 0) ? 4'hF : 4'h0, ((j / 4) % 2 == 1) ? 4'hF : 4'h0, 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
